// File: rtl/mips_pkg.sv
// Shared MIPS datapath encodings used by the MEM/WB stage and its load formatter.
package mips_pkg;
  localparam int WORD_W = 32;

  localparam logic [1:0] RESULT_ALU  = 2'b00;
  localparam logic [1:0] RESULT_LOAD = 2'b01;
  localparam logic [1:0] RESULT_LINK = 2'b10;

  localparam logic [1:0] LOAD_BYTE = 2'b00;
  localparam logic [1:0] LOAD_HALF = 2'b01;
  localparam logic [1:0] LOAD_WORD = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/load_align.sv
// Big-endian byte/half extraction with sign/zero extension and misalignment detect.
module load_align
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [1:0]        offset_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic [WORD_W-1:0] data_o,
  output logic              misalign_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[31:24];
    case (offset_i)
      2'd1:    byte_sel = word_i[23:16];
      2'd2:    byte_sel = word_i[15:8];
      2'd3:    byte_sel = word_i[7:0];
      default: byte_sel = word_i[31:24];
    endcase
    // Odd half offsets still pick a half here; the fault flag discards the data.
    half_sel = offset_i[1] ? word_i[15:0] : word_i[31:16];
  end

  always_comb begin
    data_o     = word_i;
    misalign_o = 1'b0;
    case (size_i)
      LOAD_BYTE: data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
      LOAD_HALF: begin
        data_o     = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
        misalign_o = offset_i[0];
      end
      default:   misalign_o = (offset_i != 2'd0);
    endcase
  end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: formats load data, selects the write-back result,
// drives the register-file write port from flops and counts retirements.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                      Clock,
  input  logic                      Reset_N,
  input  logic                      Stall,
  input  logic                      Flush,
  input  logic                      Mem_Valid,
  input  logic                      Mem_Reg_Write,
  input  logic [REG_ADDR_WIDTH-1:0] Mem_Write_Reg,
  input  logic [1:0]                Mem_Result_Sel,
  input  logic [DATA_WIDTH-1:0]     Mem_Alu_Result,
  input  logic [DATA_WIDTH-1:0]     Mem_Load_Data,
  input  logic [1:0]                Mem_Load_Size,
  input  logic                      Mem_Load_Unsigned,
  input  logic [DATA_WIDTH-1:0]     Mem_Pc_Plus_8,
  output logic [REG_ADDR_WIDTH-1:0] Write_Reg,
  output logic [DATA_WIDTH-1:0]     Write_Data,
  output logic                      Reg_Write,
  output logic                      Wb_Valid,
  output logic                      Load_Fault,
  output logic [COUNT_WIDTH-1:0]    Retire_Count
);
  logic [DATA_WIDTH-1:0]     load_fmt;
  logic                      misalign;
  logic [DATA_WIDTH-1:0]     result;
  logic                      fault_d, reg_write_d, wb_valid_d;
  logic [DATA_WIDTH-1:0]     wdata_d;

  logic [REG_ADDR_WIDTH-1:0] wreg_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic                      reg_write_q, wb_valid_q, fault_q;
  logic [COUNT_WIDTH-1:0]    cnt_q;

  load_align u_align (
    .word_i     (Mem_Load_Data),
    .offset_i   (Mem_Alu_Result[1:0]),
    .size_i     (Mem_Load_Size),
    .unsigned_i (Mem_Load_Unsigned),
    .data_o     (load_fmt),
    .misalign_o (misalign)
  );

  always_comb begin
    case (Mem_Result_Sel)
      RESULT_LOAD: result = load_fmt;
      RESULT_LINK: result = Mem_Pc_Plus_8;
      default:     result = Mem_Alu_Result;
    endcase
    fault_d     = Mem_Valid & (Mem_Result_Sel == RESULT_LOAD) & misalign;
    wdata_d     = fault_d ? '0 : result;
    wb_valid_d  = Mem_Valid & ~fault_d;
    reg_write_d = wb_valid_d & Mem_Reg_Write & (Mem_Write_Reg != REG_ADDR_WIDTH'(REG_ZERO));
  end

  // Flush only clears the qualifiers; the data fields are dead once they drop.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      wreg_q      <= '0;
      wdata_q     <= '0;
      reg_write_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      fault_q     <= 1'b0;
      cnt_q       <= '0;
    end else if (Flush) begin
      reg_write_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else if (!Stall) begin
      wreg_q      <= Mem_Write_Reg;
      wdata_q     <= wdata_d;
      reg_write_q <= reg_write_d;
      wb_valid_q  <= wb_valid_d;
      fault_q     <= fault_d;
      if (wb_valid_d) cnt_q <= cnt_q + COUNT_WIDTH'(1);
    end
  end

  assign Write_Reg    = wreg_q;
  assign Write_Data   = wdata_q;
  assign Reg_Write    = reg_write_q;
  assign Wb_Valid     = wb_valid_q;
  assign Load_Fault   = fault_q;
  assign Retire_Count = cnt_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboarded random + directed bench for mem_wb_stage (32-bit and 4-bit counter builds).
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, mvalid = 1'b0, mrw = 1'b0, muns = 1'b0;
  logic [4:0]  mwreg = '0;
  logic [1:0]  msel = '0, msize = '0;
  logic [31:0] malu = '0, mld = '0, mpc8 = '0;

  logic [4:0]  wreg, wreg4;
  logic [31:0] wdata, wdata4, cnt;
  logic [3:0]  cnt4;
  logic        rw, wv, fault, rw4, wv4, fault4;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .Clock(clk), .Reset_N(rst_n), .Stall(stall), .Flush(flush), .Mem_Valid(mvalid),
    .Mem_Reg_Write(mrw), .Mem_Write_Reg(mwreg), .Mem_Result_Sel(msel),
    .Mem_Alu_Result(malu), .Mem_Load_Data(mld), .Mem_Load_Size(msize),
    .Mem_Load_Unsigned(muns), .Mem_Pc_Plus_8(mpc8), .Write_Reg(wreg),
    .Write_Data(wdata), .Reg_Write(rw), .Wb_Valid(wv), .Load_Fault(fault),
    .Retire_Count(cnt)
  );

  mem_wb_stage #(.COUNT_WIDTH(4)) dut4 (
    .Clock(clk), .Reset_N(rst_n), .Stall(stall), .Flush(flush), .Mem_Valid(mvalid),
    .Mem_Reg_Write(mrw), .Mem_Write_Reg(mwreg), .Mem_Result_Sel(msel),
    .Mem_Alu_Result(malu), .Mem_Load_Data(mld), .Mem_Load_Size(msize),
    .Mem_Load_Unsigned(muns), .Mem_Pc_Plus_8(mpc8), .Write_Reg(wreg4),
    .Write_Data(wdata4), .Reg_Write(rw4), .Wb_Valid(wv4), .Load_Fault(fault4),
    .Retire_Count(cnt4)
  );

  typedef struct {
    logic        rw, wv, fault;
    logic [4:0]  wreg;
    logic [31:0] wdata, cnt;
  } exp_t;

  exp_t q[$];
  exp_t m;  // reference model of the architecturally visible WB entry
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m = '{rw: 1'b0, wv: 1'b0, fault: 1'b0, wreg: 5'd0, wdata: 32'd0, cnt: 32'd0};
  endfunction

  // Apply inputs now and push the expected post-edge WB entry.
  task automatic drive_now(input logic v, input logic w, input logic [4:0] r,
                           input logic [1:0] sel, input logic [31:0] alu,
                           input logic [31:0] ld, input logic [1:0] sz, input logic u,
                           input logic [31:0] pc8, input logic st, input logic fl);
    int          off;
    logic [31:0] val, res;
    logic        mis;
    mvalid = v; mrw = w; mwreg = r; msel = sel; malu = alu; mld = ld;
    msize = sz; muns = u; mpc8 = pc8; stall = st; flush = fl;
    off = int'(alu[1:0]);
    if (sz == 2'd0) begin
      val = (ld >> (8 * (3 - off))) & 32'hFF;
      if (!u && val[7]) val = val | 32'hFFFF_FF00;
      mis = 1'b0;
    end else if (sz == 2'd1) begin
      val = (ld >> (off >= 2 ? 0 : 16)) & 32'hFFFF;
      if (!u && val[15]) val = val | 32'hFFFF_0000;
      mis = (off % 2) != 0;
    end else begin
      val = ld;
      mis = off != 0;
    end
    res = (sel == 2'd1) ? val : (sel == 2'd2) ? pc8 : alu;
    if (fl) begin
      m.rw = 1'b0; m.wv = 1'b0; m.fault = 1'b0;
    end else if (!st) begin
      m.fault = v && sel == 2'd1 && mis;
      m.wv    = v && !m.fault;
      m.rw    = m.wv && w && r != 5'd0;
      m.wreg  = r;
      m.wdata = m.fault ? 32'd0 : res;
      if (m.wv) m.cnt = m.cnt + 1;
    end
    q.push_back(m);
  endtask

  task automatic drive(input logic v, input logic w, input logic [4:0] r,
                       input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] ld, input logic [1:0] sz, input logic u,
                       input logic [31:0] pc8, input logic st, input logic fl);
    @(negedge clk);
    drive_now(v, w, r, sel, alu, ld, sz, u, pc8, st, fl);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_reg_write", {31'd0, rw}, 32'd0);
    chk("rst_wb_valid", {31'd0, wv}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_write_reg", {27'd0, wreg}, 32'd0);
    chk("rst_write_data", wdata, 32'd0);
    chk("rst_retire", cnt, 32'd0);
    chk("rst_retire4", {28'd0, cnt4}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive_now(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one WB entry is expected after every edge that had stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("reg_write", {31'd0, rw}, {31'd0, e.rw});
        chk("wb_valid", {31'd0, wv}, {31'd0, e.wv});
        chk("load_fault", {31'd0, fault}, {31'd0, e.fault});
        if (e.wv || e.fault) chk("write_data", wdata, e.wdata);
        if (e.wv) chk("write_reg", {27'd0, wreg}, {27'd0, e.wreg});
        chk("retire", cnt, e.cnt);
        chk("retire4", {28'd0, cnt4}, {28'd0, e.cnt[3:0]});
      end
    end
  end

  initial begin
    logic [1:0] ofs;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive_now(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 4; i++) begin
      ofs = 2'(i);
      drive(1, 1, 5'd3, 2'd1, {30'h100, ofs}, 32'h80FF7F01, 2'd0, 1'b0, 0, 0, 0);
      drive(1, 1, 5'd4, 2'd1, {30'h100, ofs}, 32'h80FF7F01, 2'd0, 1'b1, 0, 0, 0);
    end
    drive(1, 1, 5'd6, 2'd1, 32'h0000_1002, 32'h80FF7F01, 2'd1, 1'b0, 0, 0, 0);
    drive(1, 1, 5'd6, 2'd1, 32'h0000_1001, 32'h80FF7F01, 2'd2, 1'b0, 0, 0, 0);
    drive(1, 1, 5'd6, 2'd1, 32'h0000_1003, 32'h80FF7F01, 2'd1, 1'b0, 0, 0, 0);
    drive(1, 1, 5'd0, 2'd0, 32'd1234, 0, 2'd2, 1'b0, 0, 0, 0);
    drive(1, 1, 5'd31, 2'd2, 32'h0, 0, 2'd2, 1'b0, 32'h0040_0010, 0, 0);
    drive(1, 1, 5'd5, 2'd0, 32'h0000_0055, 0, 2'd2, 1'b0, 0, 0, 0);
    repeat (3) drive(1, 1, 5'd9, 2'd0, 32'hDEAD_BEEF, 0, 2'd2, 1'b0, 0, 1, 0);
    drive(1, 1, 5'd9, 2'd0, 32'hDEAD_BEEF, 0, 2'd2, 1'b0, 0, 1, 1);
    drive(1, 1, 5'd7, 2'd0, 32'h0000_0077, 0, 2'd2, 1'b0, 0, 0, 0);
    do_reset();

    // Sixteen retirements wrap the 4-bit counter back to zero.
    for (int i = 0; i < 16; i++) drive(1, 1, 5'd1, 2'd0, 32'(i), 0, 2'd2, 1'b0, 0, 0, 0);

    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 1), 5'($urandom_range(0, 7) == 0 ? 0 : $urandom),
            2'($urandom), $urandom, $urandom, 2'($urandom), 1'($urandom), $urandom,
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10);
    drive(1, 1, 5'd2, 2'd0, 32'h0000_00AA, 0, 2'd2, 1'b0, 0, 0, 0);
    do_reset();
    drive(1, 1, 5'd8, 2'd1, 32'h0000_2000, 32'hCAFE_F00D, 2'd2, 1'b0, 0, 0, 0);

    @(posedge clk); #3;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
